// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio sample width and stereo pair types
package audio_pkg;

  localparam int AUDIO_SAMPLE_W = 16;

  typedef logic signed [AUDIO_SAMPLE_W-1:0] audio_sample_t;

  typedef struct packed {
    audio_sample_t left;
    audio_sample_t right;
  } stereo_pair_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// rtl/i2s_clk_gen.sv - BCLK divider, frame bit counter and LRCLK generation
module i2s_clk_gen #(
  parameter int BCLK_DIV  = 4,
  parameter int SLOT_W    = 16,
  parameter int BIT_CNT_W = $clog2(2 * SLOT_W)
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 bclk,
  output logic                 lrclk,
  output logic                 fall_evt,
  output logic                 frame_start,
  output logic [BIT_CNT_W-1:0] bit_cnt
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0]     DIV_LAST   = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_CNT_W-1:0] FRAME_LAST = BIT_CNT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_CNT_W-1:0] SLOT_FIRST_R = BIT_CNT_W'(SLOT_W);

  logic [DIV_W-1:0]     div_cnt;
  logic                 wrap;
  logic [BIT_CNT_W-1:0] bit_cnt_nxt;

  assign wrap        = (div_cnt == DIV_LAST);
  assign fall_evt    = wrap & bclk;
  assign frame_start = fall_evt & (bit_cnt == FRAME_LAST);
  assign bit_cnt_nxt = (bit_cnt == FRAME_LAST) ? '0 : bit_cnt + 1'b1;

  // Divider: bclk toggles each time div_cnt wraps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Bit counter and word select advance together on bclk falling events;
  // starting at the last bit makes the first falling event a frame boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= FRAME_LAST;
      lrclk   <= 1'b1;
    end else if (fall_evt) begin
      bit_cnt <= bit_cnt_nxt;
      lrclk   <= (bit_cnt_nxt >= SLOT_FIRST_R);
    end
  end

endmodule

// File: rtl/i2s_audio_transmitter.sv
// rtl/i2s_audio_transmitter.sv - I2S serializer with one-pair holding register; I2S_LEFT_JUSTIFIED_EN selects left-justified format
module i2s_audio_transmitter
  import audio_pkg::*;
#(
  parameter int BCLK_DIV = 4,
  parameter int SLOT_W   = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic signed [AUDIO_SAMPLE_W-1:0] left_sample,
  input  logic signed [AUDIO_SAMPLE_W-1:0] right_sample,
  input  logic                             sample_valid,
  output logic                             sample_ready,
  output logic                             i2s_bclk,
  output logic                             i2s_lrclk,
  output logic                             i2s_sdata,
  output logic                             underrun
);

  localparam int FRAME_W   = 2 * SLOT_W;
  localparam int BIT_CNT_W = $clog2(FRAME_W);
  localparam logic [BIT_CNT_W-1:0] FRAME_LAST = BIT_CNT_W'(FRAME_W - 1);

  stereo_pair_t         hold_pair;
  logic                 hold_full;
  logic                 take;
  logic [FRAME_W-1:0]   frame_q;
  logic [FRAME_W-1:0]   load_frame;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [BIT_CNT_W-1:0] sel_idx;
  logic                 fall_evt;
  logic                 frame_start;

  i2s_clk_gen #(
    .BCLK_DIV  (BCLK_DIV),
    .SLOT_W    (SLOT_W),
    .BIT_CNT_W (BIT_CNT_W)
  ) u_clk_gen (
    .clk         (clk),
    .reset       (reset),
    .bclk        (i2s_bclk),
    .lrclk       (i2s_lrclk),
    .fall_evt    (fall_evt),
    .frame_start (frame_start),
    .bit_cnt     (bit_cnt)
  );

  assign sample_ready = ~hold_full;
  assign take         = sample_valid & ~hold_full;

  // Frame bit i lives at frame_q[FRAME_W-1-i]; bit_cnt is the pre-event count,
  // so standard I2S emits bit bit_cnt and left-justified emits bit bit_cnt+1
`ifdef I2S_LEFT_JUSTIFIED_EN
  assign sel_idx = FRAME_LAST - bit_cnt - 1'b1;
`else
  assign sel_idx = FRAME_LAST - bit_cnt;
`endif

  // Next frame image: left then right, each MSB first and zero-padded to the slot
  always_comb begin
    load_frame = '0;
    if (hold_full) begin
      load_frame[FRAME_W-1 -: AUDIO_SAMPLE_W] = hold_pair.left;
      load_frame[SLOT_W-1  -: AUDIO_SAMPLE_W] = hold_pair.right;
    end
  end

  // Holding register: the boundary unload wins; a pair taken at an empty
  // boundary only becomes visible to the following frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_pair <= '0;
    end else if (frame_start && hold_full) begin
      hold_full <= 1'b0;
    end else if (take) begin
      hold_full <= 1'b1;
      hold_pair <= '{left: left_sample, right: right_sample};
    end
  end

  // Frame register load, serial data selection and underrun flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_q   <= '0;
      i2s_sdata <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= frame_start & ~hold_full;
      if (frame_start) begin
        frame_q <= load_frame;
      end
      if (fall_evt) begin
`ifdef I2S_LEFT_JUSTIFIED_EN
        i2s_sdata <= frame_start ? load_frame[FRAME_W-1] : frame_q[sel_idx];
`else
        i2s_sdata <= frame_q[sel_idx];
`endif
      end
    end
  end

endmodule

// File: tb/tb_i2s_audio_transmitter.sv
// tb/tb_i2s_audio_transmitter.sv - directed bench for i2s_audio_transmitter
module tb_i2s_audio_transmitter;

  localparam int BCLK_DIV = 2;
  localparam int SLOT_W   = 16;
`ifdef I2S_LEFT_JUSTIFIED_EN
  localparam bit LJ = 1'b1;
`else
  localparam bit LJ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] left_sample = '0;
  logic [15:0] right_sample = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic        underrun;

  int checks = 0;
  int failures = 0;
  int cyc;
  int und_cnt = 0;
  int und_snap;
  logic [31:0] frames_q[$];
  logic [31:0] exp_frames[5];

  i2s_audio_transmitter #(
    .BCLK_DIV (BCLK_DIV),
    .SLOT_W   (SLOT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .left_sample  (left_sample),
    .right_sample (right_sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  // Receiver model: samples sdata on bclk rising edges and rebuilds 32-bit frames
  initial begin : decoder
    logic        prev_bclk;
    logic        prev_lr;
    int          r;
    int          nbits;
    int          idx;
    logic [31:0] cur;
    prev_bclk = 1'b0; prev_lr = 1'b1; r = -1; nbits = 0; cur = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_bclk = 1'b0; prev_lr = 1'b1; r = -1; nbits = 0; cur = '0;
      end else begin
        if (underrun) und_cnt++;
        if (i2s_bclk && !prev_bclk) begin
          if (!i2s_lrclk && prev_lr) r = 0;
          else if (r >= 0) r++;
          prev_lr = i2s_lrclk;
          if (r >= 0) begin
            idx = LJ ? (r % 32) : ((r + 31) % 32);
            cur[31 - idx] = i2s_sdata;
            nbits++;
            if (idx == 31) begin
              if (nbits == 32) frames_q.push_back(cur);
              nbits = 0;
              cur = '0;
            end
          end
        end
        prev_bclk = i2s_bclk;
      end
    end
  end

  initial begin
    exp_frames[0] = 32'h8001_7FFE;
    exp_frames[1] = 32'h0000_0000;
    exp_frames[2] = 32'h1234_ABCD;
    exp_frames[3] = 32'h13F1_E00E;
    exp_frames[4] = 32'h13F2_E00D;

    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_bclk", i2s_bclk, 0);
    check("rst_lrclk", i2s_lrclk, 1);
    check("rst_sdata", i2s_sdata, 0);
    check("rst_ready", sample_ready, 1);
    check("rst_underrun", underrun, 0);

    reset = 1'b0;
    sample_valid = 1'b1; left_sample = 16'h8001; right_sample = 16'h7FFE;
    wait_cyc(1);
    check("a_taken_ready", sample_ready, 0);
    sample_valid = 1'b0;
    wait_cyc(2);
    check("c2_bclk", i2s_bclk, 1);
    wait_cyc(3);
    check("c3_bclk", i2s_bclk, 1);
    check("c3_lrclk", i2s_lrclk, 1);
    wait_cyc(4);
    check("c4_bclk", i2s_bclk, 0);
    check("c4_lrclk", i2s_lrclk, 0);
    check("c4_ready", sample_ready, 1);
    check("c4_underrun", underrun, 0);
    check("c4_sdata", i2s_sdata, LJ ? 1 : 0);
    wait_cyc(8);
    check("c8_sdata", i2s_sdata, LJ ? 0 : 1);
    check("c8_lrclk", i2s_lrclk, 0);

    wait_cyc(131);
    check("c131_ready", sample_ready, 1);
    check("c131_und_cnt", und_cnt, 0);
    sample_valid = 1'b1; left_sample = 16'h1234; right_sample = 16'hABCD;
    wait_cyc(132);
    check("c132_underrun", underrun, 1);
    check("c132_ready", sample_ready, 0);
    left_sample = 16'h13F1; right_sample = 16'hE00E;
    wait_cyc(133);
    check("c133_underrun", underrun, 0);

    wait_cyc(259);
    check("c259_ready", sample_ready, 0);
    wait_cyc(260);
    check("c260_ready", sample_ready, 1);
    wait_cyc(261);
    check("c261_ready", sample_ready, 0);
    left_sample = 16'h13F2; right_sample = 16'hE00D;
    wait_cyc(388);
    check("c388_ready", sample_ready, 1);
    wait_cyc(389);
    check("c389_ready", sample_ready, 0);
    left_sample = 16'h13F3; right_sample = 16'hE00C;
    wait_cyc(517);
    check("c517_ready", sample_ready, 0);
    left_sample = 16'h5A5A; right_sample = 16'hA5A5;
    wait_cyc(645);
    check("c645_ready", sample_ready, 0);
    sample_valid = 1'b0;

    wait_cyc(650);
    check("frame_count", frames_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("frame%0d", i), (frames_q.size() > i) ? frames_q[i] : 32'hDEAD_BEEF, exp_frames[i]);
    end

    wait_cyc(673);
    check("c673_und_cnt", und_cnt, 1);
    check("c673_sdata", i2s_sdata, 1);
    check("c673_lrclk", i2s_lrclk, 0);
    check("c673_ready", sample_ready, 0);
    reset = 1'b1;
    #1;
    check("mid_rst_bclk", i2s_bclk, 0);
    check("mid_rst_lrclk", i2s_lrclk, 1);
    check("mid_rst_sdata", i2s_sdata, 0);
    check("mid_rst_ready", sample_ready, 1);
    check("mid_rst_underrun", underrun, 0);
    frames_q.delete();
    und_snap = und_cnt;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    wait_cyc(3);
    check("r3_bclk", i2s_bclk, 1);
    check("r3_lrclk", i2s_lrclk, 1);
    wait_cyc(4);
    check("r4_bclk", i2s_bclk, 0);
    check("r4_lrclk", i2s_lrclk, 0);
    check("r4_underrun", underrun, 1);
    check("r4_ready", sample_ready, 1);
    wait_cyc(140);
    check("post_rst_frame", (frames_q.size() > 0) ? frames_q[0] : 32'hDEAD_BEEF, 32'h0);
    check("post_rst_und_cnt", und_cnt, und_snap + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_audio_transmitter.md
# i2s_audio_transmitter

Serializes the volume-scaled stereo samples from the output stage into a standard I2S stream (BCLK, LRCLK, SDATA) for the external DAC/codec. Sits after the volume stage at the far end of the audio path. Contains a one-entry holding register with a valid/ready handshake, a BCLK divider, a frame bit counter and a shift register. When no sample is available at a frame boundary, it signals an underrun and transmits silence.

## Interface
- `BCLK_DIV`, default 4: clk cycles per BCLK half-period; must be ≥2.
- `SLOT_W`, default 16: BCLK cycles per channel slot; must be ≥16. Bits beyond the 16 sample bits are zero.
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `left_sample`, input, 16: signed left sample, two's complement.
- `right_sample`, input, 16: signed right sample, two's complement.
- `sample_valid`, input, 1: the left/right pair is valid.
- `sample_ready`, output, 1: holding register is empty; a transfer occurs when valid and ready are both 1 on a rising edge of clk.
- `i2s_bclk`, output, 1: bit clock, registered.
- `i2s_lrclk`, output, 1: word select; 0 = left, 1 = right.
- `i2s_sdata`, output, 1: serial data, MSB first.
- `underrun`, output, 1: one-clk pulse when a frame starts with the holding register empty.

## Operation
- **Divider:** `div_cnt` counts 0..BCLK_DIV-1. On wrap, `i2s_bclk` toggles.
  - A rising event is a wrap while bclk=0.
  - A falling event is a wrap while bclk=1.
- **Bit counter:** `bit_cnt` ranges over 0..2·SLOT_W-1 and advances on each falling event.
  - `i2s_lrclk` = (bit_cnt ≥ SLOT_W), registered on the falling event.
- **Frame boundary:** the falling event at which `bit_cnt` wraps to 0.
  - If the holding register is full, the shift register loads {left, zero-pad, right, zero-pad} and the holding register empties.
  - If the holding register is empty, the shift register loads all zeros and `underrun` pulses for one clk.
- **sdata (I2S format):** on each falling event, output the frame bit at index bit_cnt-1 (mod 2·SLOT_W). The left MSB therefore appears one BCLK after LRCLK falls. On the boundary itself, the last bit of the previous frame is driven.
- **Handshake:**
  - `sample_ready` = !hold_full, combinational from the register.
  - A transfer sets hold_full.
  - In the boundary cycle, the unload takes precedence: ready is 0 that cycle if the register was full and 1 the next cycle.
  - A sample accepted in the same clk as an empty-register boundary is not used by that frame; that frame underruns.
- `sample_valid` may stay high; each transfer consumes exactly one pair.
- Reset mid-frame:
  - All state returns to reset values immediately and asynchronously.
  - A held pair is discarded.
  - Serialization restarts at a fresh frame boundary.

## Timing
- Reset values:
  - `i2s_bclk`=0, `i2s_lrclk`=1, `i2s_sdata`=0.
  - `sample_ready`=1, `underrun`=0.
  - `div_cnt`=0, `bit_cnt`=2·SLOT_W-1, shift register=0.
- The first falling event, which is also the first frame boundary, occurs on the 2·BCLK_DIV-th clk edge after reset deasserts.
- All outputs are registered and change only on falling events of BCLK, except `sample_ready` and `underrun`.
- Frame period is 4·SLOT_W·BCLK_DIV clk cycles.
- Latency from a transfer to its left MSB on `i2s_sdata`: from the next frame boundary plus one BCLK period (I2S format).
- Sustained throughput is one pair per frame, with no underrun, provided each pair is presented before its boundary.

## Configuration
- `I2S_LEFT_JUSTIFIED_EN` defined: left-justified format with no one-bit delay.
  - sdata on each falling event is the frame bit at index bit_cnt.
  - The left MSB coincides with the LRCLK falling edge.
- Not defined: standard I2S with the one-BCLK delay described above.
- The LRCLK polarity and the handshake are identical in both modes.

## Structure
- Shared package `audio_pkg`:
  - constant `AUDIO_SAMPLE_W` = 16.
  - typedef `audio_sample_t` (signed 16-bit).
  - typedef `stereo_pair_t` (left, right).
- The volume stage and this block both use `audio_pkg`.
- One sub-module: `i2s_clk_gen`, which contains the divider, the bit counter and LRCLK generation. It outputs a one-clk `fall_evt` pulse, a `frame_start` pulse and `bit_cnt`.
- The top level holds the holding register, the shift register and the sdata selection.

## Test plan
All scenarios use BCLK_DIV=2 and SLOT_W=16.
- **Reset:** hold reset high. → bclk=0, lrclk=1, sdata=0, ready=1, underrun=0. After release, the first bclk falling edge comes at clk 4 and lrclk goes to 0.
- **Single pair:** push L=16'h8001, R=16'h7FFE before the first boundary.
  - → Sampled on BCLK rising edges, sdata bits 1..16 after the LRCLK fall read 1000_0000_0000_0001.
  - → After the LRCLK rise, the right slot reads 0111_1111_1111_1110.
  - → No underrun pulse.
- **Back-pressure:** hold valid high with incrementing pairs. → ready drops after each transfer and rises in the clk after each boundary. Exactly one pair is transmitted per 128-clk frame, in order, with none lost or duplicated.
- **Underrun:** no valid at a boundary. → `underrun` pulses for exactly one clk and the frame is all zeros. A pair presented on that same boundary clk appears in the next frame.
- **Reset mid-frame:** assert reset at bit_cnt=7 of a left slot while a pair is held. → Outputs return to reset values at once and the held pair is never transmitted. After release, timing matches the reset scenario.
- **`I2S_LEFT_JUSTIFIED_EN`:** L=16'h8001. → The left MSB=1 is driven on the same falling edge as the LRCLK fall, and the LSB is on bit 15.
